// File: rtl/ok_core_bd_core_pkg.sv
// Shared definitions for the host<->Braindrop bridge.
// - Horn routing tables: each valid leaf maps to a prefix-free route code
//   (0xxx, 10xxxx, 11xxxxx) and its length. The route code fills the top of
//   the 21-bit BD word and the payload fills the low bits.
// - Host word type encoding, the NOP words in each direction, register ids,
//   and the tag carried by upstream host words.
package bd_pkg;

  localparam int HORN_LEAVES = 34;

  localparam logic [6:0] HORN_ROUTE [0:33] = '{
    7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07,
    7'h20, 7'h21, 7'h22, 7'h23, 7'h24, 7'h25, 7'h26, 7'h27,
    7'h28, 7'h29, 7'h2A, 7'h2B, 7'h2C, 7'h2D, 7'h2E, 7'h2F,
    7'h60, 7'h61, 7'h62, 7'h63, 7'h64, 7'h65, 7'h66, 7'h67,
    7'h68, 7'h69
  };

  localparam logic [4:0] HORN_LEN [0:33] = '{
    5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4,
    5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6,
    5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6,
    5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7,
    5'd7, 5'd7
  };

  typedef enum logic [1:0] {
    WT_BD   = 2'b00,
    WT_NOP  = 2'b01,
    WT_REG  = 2'b10,
    WT_CHAN = 2'b11
  } word_t;

  localparam logic [31:0] NOP_DN     = 32'hBF00_0001;
  localparam logic [31:0] NOP_UP     = 32'hBF00_0001;
  localparam logic [5:0]  REG_RESETS = 6'd31;
  localparam logic [5:0]  REG_ADC    = 6'd30;
  localparam logic [7:0]  US_TAG     = 8'hFF;

  // Downstream FIFO entry: the leaf is kept so encoding happens at the head.
  typedef struct packed {
    logic [5:0]  leaf;
    logic [19:0] payload;
  } ds_word_t;

  // Route code left-justified in 21 bits, payload truncated to the bits
  // the route leaves free.
  function automatic logic [20:0] horn_encode(logic [5:0] leaf, logic [19:0] payload);
    logic [4:0]  sh;
    logic [20:0] mask;
    logic [20:0] route;
    sh    = 5'd21 - HORN_LEN[leaf];
    mask  = (21'd1 << sh) - 21'd1;
    route = {14'd0, HORN_ROUTE[leaf]} << sh;
    return route | ({1'b0, payload} & mask);
  endfunction

endpackage

// File: rtl/ok_core_bd_core_if.sv
// Handshake bundle between the bridge core and its neighbours.
// - pipe_in_*  : host downstream words (valid/ready)
// - pipe_out_* : host upstream words (data always presented, read consumes)
// - BD_out_*   : horn-encoded words to the chip (valid/ready)
// - BD_in_*    : words from the chip (valid is active low)
// slave = the core, master = host/chip side.
interface ok_core_bd_core_if;
  logic [31:0] pipe_in_data;
  logic        pipe_in_valid;
  logic        pipe_in_ready;
  logic [31:0] pipe_out_data;
  logic        pipe_out_read;
  logic [20:0] BD_out_data;
  logic        BD_out_valid;
  logic        BD_out_ready;
  logic [33:0] BD_in_data;
  logic        _BD_in_valid;
  logic        BD_in_ready;

  modport slave (
    input  pipe_in_data, pipe_in_valid, pipe_out_read, BD_out_ready, BD_in_data, _BD_in_valid,
    output pipe_in_ready, pipe_out_data, BD_out_data, BD_out_valid, BD_in_ready
  );

  modport master (
    output pipe_in_data, pipe_in_valid, pipe_out_read, BD_out_ready, BD_in_data, _BD_in_valid,
    input  pipe_in_ready, pipe_out_data, BD_out_data, BD_out_valid, BD_in_ready
  );
endinterface

// File: rtl/ok_core_bd_core_sync_fifo.sv
// Single-clock FIFO with fall-through read data (rdata = current head).
// Ports: clk, rst_n (async low), push/wdata, pop/rdata, full, empty.
// Push while full is accepted only if a pop happens in the same cycle;
// pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/ok_core_bd_core.sv
// Host<->Braindrop bridge core.
// Downstream: host words are decoded into register writes (ids 30/31) or
// BD words (valid leaves only) that queue for horn encoding toward the chip.
// Upstream: 34-bit chip words queue and are serialized into two tagged
// 32-bit host words, low half first.
// Ports: clk, reset_n (async low), bus (handshakes, slave side),
//   BD_out_clk/BD_in_clk (forwarded clk), pReset/sReset (reg31[1:0]),
//   adc0/adc1 (reg30[1:0]), led {overflow sticky, ds nonempty, sReset, pReset}.
module ok_core_bd_core
  import bd_pkg::*;
#(
  parameter int DS_FIFO_DEPTH = 16,
  parameter int US_FIFO_DEPTH = 16,
  parameter int NUM_LEAVES    = HORN_LEAVES
) (
  input  logic                clk,
  input  logic                reset_n,
  ok_core_bd_core_if.slave    bus,
  output logic                BD_out_clk,
  output logic                BD_in_clk,
  output logic                pReset,
  output logic                sReset,
  output logic                adc0,
  output logic                adc1,
  output logic [3:0]          led
);
  localparam logic [5:0] LEAF_LIM = 6'(NUM_LEAVES);

  ds_word_t    ds_wdata, ds_rdata;
  logic        ds_push, ds_pop, ds_full, ds_empty;
  logic [33:0] us_rdata;
  logic        us_push, us_pop, us_full, us_empty;

  logic        in_en;      // holds pipe_in_ready low until the first clock out of reset
  logic        phase;      // 0: low half of head goes out next, 1: high half
  logic        ovf;
  logic [1:0]  r30, r31;

  word_t       wtype;
  logic [5:0]  id;
  logic        in_xfer, reg_wr, bd_in_vld;
  logic        unused_bits;

  assign BD_out_clk = clk;
  assign BD_in_clk  = clk;

  assign wtype   = word_t'(bus.pipe_in_data[31:30]);
  assign id      = bus.pipe_in_data[29:24];
  assign in_xfer = bus.pipe_in_valid & bus.pipe_in_ready;
  assign reg_wr  = in_xfer && (wtype == WT_REG) && (bus.pipe_in_data != NOP_DN);

  // Every word type stalls on a full FIFO, not just BD words.
  assign bus.pipe_in_ready = in_en & ~ds_full;

  assign ds_push  = in_xfer && (wtype == WT_BD) && (id < LEAF_LIM);
  assign ds_wdata = '{leaf: id, payload: bus.pipe_in_data[19:0]};

  // Valid is masked by pReset without popping, so queued words survive a chip reset.
  assign bus.BD_out_valid = ~ds_empty & ~pReset;
  assign bus.BD_out_data  = horn_encode(ds_rdata.leaf, ds_rdata.payload);
  assign ds_pop           = bus.BD_out_valid & bus.BD_out_ready;

  assign bd_in_vld       = ~bus._BD_in_valid;
  assign bus.BD_in_ready = ~us_full & ~pReset;
  assign us_push         = bd_in_vld & bus.BD_in_ready;
  assign us_pop          = bus.pipe_out_read & ~us_empty & phase;

  always_comb begin
    bus.pipe_out_data = NOP_UP;
    if (!us_empty)
      bus.pipe_out_data = phase ? {US_TAG, 14'd0, us_rdata[33:24]}
                                : {US_TAG, us_rdata[23:0]};
  end

  assign pReset = r31[0];
  assign sReset = r31[1];
  assign adc0   = r30[0];
  assign adc1   = r30[1];
  assign led    = {ovf, ~ds_empty, sReset, pReset};

  assign unused_bits = ^bus.pipe_in_data[23:20];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_en <= 1'b0;
      r30   <= 2'b00;
      r31   <= 2'b11;
      phase <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      in_en <= 1'b1;
      if (reg_wr && id == REG_RESETS) r31 <= bus.pipe_in_data[1:0];
      if (reg_wr && id == REG_ADC)    r30 <= bus.pipe_in_data[1:0];
      // Phase is only advanced by real reads, so it carries across host blocks.
      if (bus.pipe_out_read && !us_empty) phase <= ~phase;
      if (bd_in_vld && us_full && !pReset) ovf <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH($bits(ds_word_t)), .DEPTH(DS_FIFO_DEPTH)) u_ds_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (ds_push),
    .wdata (ds_wdata),
    .pop   (ds_pop),
    .rdata (ds_rdata),
    .full  (ds_full),
    .empty (ds_empty)
  );

  sync_fifo #(.WIDTH(34), .DEPTH(US_FIFO_DEPTH)) u_us_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (us_push),
    .wdata (bus.BD_in_data),
    .pop   (us_pop),
    .rdata (us_rdata),
    .full  (us_full),
    .empty (us_empty)
  );
endmodule

// File: tb/tb_ok_core_bd_core.sv
module tb_ok_core_bd_core;
  import bd_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ok_core_bd_core_if bif();
  logic BD_out_clk, BD_in_clk, pReset, sReset, adc0, adc1;
  logic [3:0] led;

  ok_core_bd_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bif),
    .BD_out_clk (BD_out_clk),
    .BD_in_clk  (BD_in_clk),
    .pReset     (pReset),
    .sReset     (sReset),
    .adc0       (adc0),
    .adc1       (adc1),
    .led        (led)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [20:0] ds_exp [$];
  logic [31:0] us_exp [$];
  bit rnd_on = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic fail(string name, logic [63:0] got);
    n_checks++;
    $display("FAIL %s: got %0h", name, got);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference horn code: 0xxx for leaves 0-7, 10xxxx for 8-23, 11xxxxx for 24-33.
  function automatic logic [20:0] exp_horn(int leaf, logic [19:0] pl);
    int n, r;
    logic [20:0] w;
    if (leaf < 8)       begin n = 4; r = leaf; end
    else if (leaf < 24) begin n = 6; r = 32 + leaf - 8; end
    else                begin n = 7; r = 96 + leaf - 24; end
    w = 21'(r) << (21 - n);
    w = w | (21'(pl) & ((21'd1 << (21 - n)) - 21'd1));
    return w;
  endfunction

  function automatic logic [31:0] bd_word(int leaf, logic [19:0] pl);
    return {2'b00, 6'(leaf), 4'h0, pl};
  endfunction

  task automatic push_us_exp(logic [33:0] d);
    us_exp.push_back({8'hFF, d[23:0]});
    us_exp.push_back({8'hFF, 14'd0, d[33:24]});
  endtask

  task automatic send(logic [31:0] w);
    bit acc = 0;
    bif.pipe_in_data  = w;
    bif.pipe_in_valid = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = bif.pipe_in_ready;
      @(posedge clk);
      #1;
    end
    bif.pipe_in_valid = 1'b0;
    if (!acc) fail("send_timeout", w);
  endtask

  task automatic bd_in_word(logic [33:0] d);
    bit acc = 0;
    bif.BD_in_data   = d;
    bif._BD_in_valid = 1'b0;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = bif.BD_in_ready;
      @(posedge clk);
      if (acc) push_us_exp(d);
      #1;
    end
    bif._BD_in_valid = 1'b1;
    if (!acc) fail("bd_in_timeout", d);
  endtask

  task automatic wait_drain(int max);
    int t = 0;
    while ((ds_exp.size() != 0 || us_exp.size() != 0) && t < max) begin
      tick(1);
      t++;
    end
    if (ds_exp.size() != 0 || us_exp.size() != 0)
      fail("drain_timeout", 64'(ds_exp.size() + us_exp.size()));
  endtask

  // Monitor: compares every BD transfer and every host read against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bif.BD_out_valid && bif.BD_out_ready) begin
        if (ds_exp.size() == 0) fail("bd_out_extra", bif.BD_out_data);
        else check("bd_out", bif.BD_out_data, ds_exp.pop_front());
      end
      if (bif.pipe_out_read) begin
        if (us_exp.size() == 0) check("pipe_out_nop", bif.pipe_out_data, NOP_UP);
        else check("pipe_out", bif.pipe_out_data, us_exp.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] pl;
    bif.pipe_in_data  = '0;
    bif.pipe_in_valid = 1'b0;
    bif.pipe_out_read = 1'b0;
    bif.BD_out_ready  = 1'b0;
    bif.BD_in_data    = '0;
    bif._BD_in_valid  = 1'b1;

    // Reset state
    tick(2);
    check("rst_pipe_in_ready", bif.pipe_in_ready, 0);
    check("rst_led", led, 4'b0011);
    check("rst_bd_out_valid", bif.BD_out_valid, 0);
    check("rst_bd_in_ready", bif.BD_in_ready, 0);
    check("rst_pipe_out", bif.pipe_out_data, NOP_UP);
    check("rst_adc", {adc1, adc0}, 2'b00);
    reset_n = 1'b1;
    tick(2);
    check("rel_pipe_in_ready", bif.pipe_in_ready, 1);
    check("rel_led", led, 4'b0011);

    // BD word queued while pReset holds the chip: nothing goes out
    bif.BD_out_ready = 1'b1;
    send(bd_word(27, 20'h0));
    ds_exp.push_back(21'h18C000);
    tick(3);
    check("preset_valid_low", bif.BD_out_valid, 0);
    check("preset_led", led, 4'b0111);

    // Release both resets; the queued leaf 27 word drains
    send(32'h9F00_0000);
    wait_drain(50);
    tick(1);
    check("unreset_led", led, 4'b0000);

    // ADC register, then NOP and an unknown register id leave state alone
    send(32'h9E00_0002);
    tick(1);
    check("adc_write", {adc1, adc0}, 2'b10);
    send(32'hBF00_0001);
    send(32'h8500_FFFF);
    tick(1);
    check("reg_ignore", {adc1, adc0, sReset, pReset}, 4'b1000);

    // Upstream serialization of one chip word, then a read from empty
    bd_in_word(34'h3_1234_5678);
    check("us_exp_w0", us_exp[0], 32'hFF34_5678);
    bif.pipe_out_read = 1'b1;
    tick(3);
    bif.pipe_out_read = 1'b0;
    tick(1);

    // Dropped words: bad leaf, channel word, type 01; one good word behind them
    send(32'h2800_1234);
    send(32'hC100_0005);
    send(32'h5B00_0000);
    send(bd_word(5, 20'h12345));
    ds_exp.push_back(21'h0B2345);
    wait_drain(50);
    tick(3);
    check("drop_valid_low", bif.BD_out_valid, 0);
    check("drop_led_ds", led[2], 0);

    // Fill the downstream FIFO with the chip stalled
    bif.BD_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pl = 20'(i * 4099 + 7);
      send(bd_word(i, pl));
      ds_exp.push_back(exp_horn(i, pl));
      if (i == 14) check("ready_at_15", bif.pipe_in_ready, 1);
    end
    check("ready_full", bif.pipe_in_ready, 0);
    check("full_led_ds", led[2], 1);
    bif.BD_out_ready = 1'b1;
    wait_drain(100);

    // Random stalls in both directions, all 34 leaves
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          bif.BD_out_ready = ($urandom_range(0, 2) != 0);
          tick(1);
        end
      end
      begin
        while (rnd_on) begin
          bif.pipe_out_read = ($urandom_range(0, 1) == 1);
          tick(1);
        end
      end
      begin
        fork
          begin
            for (int i = 0; i < 34; i++) begin
              logic [19:0] p;
              p = 20'($urandom);
              ds_exp.push_back(exp_horn(i, p));
              send(bd_word(i, p));
            end
          end
          begin
            int k = 0;
            while (k < 8) begin
              logic [33:0] d;
              bit go, acc;
              d  = {2'($urandom_range(0, 3)), 32'($urandom)};
              go = ($urandom_range(0, 2) == 0);
              bif.BD_in_data   = d;
              bif._BD_in_valid = ~go;
              @(negedge clk);
              acc = go && bif.BD_in_ready;
              @(posedge clk);
              if (acc) begin push_us_exp(d); k++; end
              #1;
            end
            bif._BD_in_valid = 1'b1;
          end
        join
        wait_drain(3000);
        rnd_on = 0;
      end
    join
    bif.BD_out_ready  = 1'b1;
    bif.pipe_out_read = 1'b0;
    tick(2);

    // Upstream overflow: fill, lose one word, sticky until reset_n
    for (int i = 0; i < 16; i++) bd_in_word({2'(i), 32'(i * 32'h0101_0101)});
    check("us_full_ready", bif.BD_in_ready, 0);
    check("pre_ovf_led3", led[3], 0);
    bif.BD_in_data   = 34'h2_DEAD_BEEF;
    bif._BD_in_valid = 1'b0;
    tick(1);
    bif._BD_in_valid = 1'b1;
    tick(1);
    check("ovf_led3", led[3], 1);
    bif.pipe_out_read = 1'b1;
    tick(33);
    bif.pipe_out_read = 1'b0;
    tick(2);
    check("ovf_sticky", led[3], 1);
    reset_n = 1'b0;
    tick(1);
    check("reset_led", led, 4'b0011);
    reset_n = 1'b1;
    tick(2);
    check("post_reset_led3", led[3], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
